// File: rtl/instr_mem_fetch.sv
// Clocked instruction memory: registered one-cycle fetch port, program-load port and
// post-reset NOP clear. Define IMEM_PRELOAD_EN to start directly in RUN and skip the clear.
module instr_mem_fetch #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
`ifdef IMEM_PRELOAD_EN
  ,
  parameter string             INIT_FILE = "imem.hex"
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f_req,
  input  logic [ADDR_W-1:0]        f_addr,
  input  logic                     f_stall,
  output logic                     f_ready,
  output logic                     f_valid,
  output logic [DATA_W-1:0]        f_data,
  output logic                     f_err,
  input  logic                     p_we,
  input  logic [$clog2(DEPTH)-1:0] p_addr,
  input  logic [DATA_W-1:0]        p_data,
  output logic                     init_done
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              run_n;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

`ifdef IMEM_PRELOAD_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
  end

  assign run    = 1'b1;
  assign run_n  = 1'b1;
  assign mem_we = p_we;
  assign mem_wa = p_addr;
  assign mem_wd = p_data;
`else
  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // INIT owns the write port; program-load writes are only honoured in RUN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mem_we  = 1'b0;
    mem_wa  = p_addr;
    mem_wd  = p_data;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = NOP_WORD;
        cnt_n  = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_n = RUN;
      end
      RUN:     mem_we = p_we;
      default: state_n = INIT;
    endcase
  end

  assign run   = (state == RUN);
  assign run_n = (state_n == RUN);
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Handshake: a fetch is taken on a rising edge where f_req && f_ready; the result
  // appears with f_valid the next cycle and is held while f_valid && f_stall.
  logic [ADDR_W-3:0] idx;
  logic              bad_addr;
  logic              accept;

  assign idx      = f_addr[ADDR_W-1:2];
  assign bad_addr = (f_addr[1:0] != 2'b00) || (32'(idx) >= 32'(DEPTH));
  assign f_ready  = run && !p_we && !(f_valid && f_stall);
  assign accept   = f_req && f_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid   <= 1'b0;
      f_data    <= '0;
      f_err     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= run_n;
      if (accept) begin
        f_valid <= 1'b1;
        if (bad_addr) begin
          f_data <= NOP_WORD;
          f_err  <= 1'b1;
        end else begin
          f_data <= mem[idx[AW-1:0]];
          f_err  <= 1'b0;
        end
      end else if (!(f_valid && f_stall)) begin
        f_valid <= 1'b0;
      end
    end
  end

endmodule
